// File: rtl/pc_seq_ctrl.sv
// Fetch-stage next-PC controller: boot, sequential, JAL, EX redirect and JALR wait sequencing.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect targets vector to TRAP_VEC).
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        dec_valid,
    input  logic [31:0] dec_inst,
    input  logic [31:0] dec_pc,
    input  logic [31:0] dec_imm,
    input  logic        ex_redirect,
    input  logic        ex_is_jalr,
    input  logic [31:0] ex_target,
    output logic [31:0] pc_fetch,
    output logic        fetch_valid,
    output logic        flush_dec,
    output logic        flush_ex,
    output logic [1:0]  pc_add_sel,
    output logic        trap
);

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [1:0] SEL_PC4    = 2'b00;
    localparam logic [1:0] SEL_PC_IMM = 2'b01;
    localparam logic [1:0] SEL_RS1    = 2'b11;
`ifdef MISALIGN_TRAP_EN
    localparam logic [1:0] SEL_TRAP   = 2'b10;
`endif

    typedef enum logic [1:0] {
        S_BOOT      = 2'd0,
        S_RUN       = 2'd1,
        S_JALR_WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  pc_add_sel_q, pc_add_sel_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        trap_q, trap_d;

    logic        jal_hit, jalr_hit;
    logic [31:0] jal_tgt;
    logic        load_en;
    logic [31:0] load_tgt;
    logic [1:0]  load_sel;

    assign jal_hit  = dec_valid && (dec_inst[6:0] == OPC_JAL);
    assign jalr_hit = dec_valid && (dec_inst[6:0] == OPC_JALR);
    assign jal_tgt  = dec_pc + dec_imm;

    // Next-state, next-PC and stage-flush decode
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_add_sel_d = pc_add_sel_q;
        trap_d       = 1'b0;
        flush_dec    = 1'b0;
        flush_ex     = 1'b0;
        load_en      = 1'b0;
        load_tgt     = 32'h0;
        load_sel     = SEL_PC4;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    if (ex_redirect) begin
                        flush_dec = 1'b1;
                        flush_ex  = 1'b1;
                        load_en   = 1'b1;
                        load_tgt  = ex_target;
                        load_sel  = ex_is_jalr ? SEL_RS1 : SEL_PC_IMM;
                    end else if (jal_hit) begin
                        flush_dec = 1'b1;
                        load_en   = 1'b1;
                        load_tgt  = jal_tgt;
                        load_sel  = SEL_PC_IMM;
                    end else if (jalr_hit) begin
                        flush_dec = 1'b1;
                        state_d   = S_JALR_WAIT;
                    end else begin
                        pc_d         = pc_q + 32'd4;
                        pc_add_sel_d = SEL_PC4;
                    end
                end
            end
            S_JALR_WAIT: begin
                // Any EX redirect here is the JALR resolving, whatever ex_is_jalr says
                if (!stall) begin
                    flush_dec = 1'b1;
                    if (ex_redirect) begin
                        load_en  = 1'b1;
                        load_tgt = ex_target;
                        load_sel = SEL_RS1;
                        state_d  = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (load_en) begin
`ifdef MISALIGN_TRAP_EN
            if (load_tgt[1:0] != 2'b00) begin
                pc_d         = TRAP_VEC;
                pc_add_sel_d = SEL_TRAP;
                trap_d       = 1'b1;
            end else begin
                pc_d         = load_tgt;
                pc_add_sel_d = load_sel;
            end
`else
            pc_d         = {load_tgt[31:2], 2'b00};
            pc_add_sel_d = load_sel;
`endif
        end

        fetch_valid_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            pc_add_sel_q  <= SEL_PC4;
            fetch_valid_q <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_add_sel_q  <= pc_add_sel_d;
            fetch_valid_q <= fetch_valid_d;
            trap_q        <= trap_d;
        end
    end

    assign pc_fetch    = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign pc_add_sel  = pc_add_sel_q;
    assign trap        = trap_q;

    // Upper opcode bits and the trap vector are not needed in every build
    logic unused_ok;
    assign unused_ok = ^{dec_inst[31:7], TRAP_VEC, load_tgt[1:0]};

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Fetch-stage next-PC controller for the 3-stage RV32I pipeline.
- Owns the fetch PC register and sequences it from the boot address: sequential PC+4, decode-resolved JAL, and execute-resolved branch/JALR redirects.
- Stops speculative fetch while a JALR is in flight and generates flush pulses for the decode and execute stages.
- Reports the PC-add selection encoding of the last accepted update to the datapath.

Parameters:
- RESET_PC, 32'h4000_0000, first fetch address after reset.
- TRAP_VEC, 32'h0000_1000, misaligned-target handler address (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  front-end freeze from hazard/memory logic.
- dec_valid  in  1  decode-stage instruction is valid.
- dec_inst  in  32  decode-stage instruction; opcode is [6:0].
- dec_pc  in  32  PC of decode-stage instruction.
- dec_imm  in  32  sign-extended J-immediate of the decode-stage instruction.
- ex_redirect  in  1  execute stage resolved a taken branch or JALR.
- ex_is_jalr  in  1  qualifies ex_redirect as a JALR.
- ex_target  in  32  resolved target address.
- pc_fetch  out  32  registered PC driven to IMEM.
- fetch_valid  out  1  pc_fetch is a real fetch this cycle.
- flush_dec  out  1  combinational; kill the fetch-to-decode register contents.
- flush_ex  out  1  combinational; kill the decode-to-execute register contents.
- pc_add_sel  out  2  registered; 00 = pc4, 01 = pc_imm, 11 = rs1_imm, 10 = trap.
- trap  out  1  registered one-cycle misaligned-target pulse.

Behaviour:
- Reset (rst=1 at an edge): state=BOOT, pc_fetch=RESET_PC, pc_add_sel=00, trap=0. fetch_valid=0 and flush_dec=flush_ex=0 while in BOOT. Reset overrides everything, including a redirect in the same cycle and reset during JALR_WAIT.
- BOOT: always moves to RUN next cycle, ignoring stall; pc_fetch is unchanged, so the first valid fetch is RESET_PC.
- RUN: fetch_valid=1.
- Stall: when stall=1 in any state except BOOT, all registers hold and flush_dec=flush_ex=0. ex_redirect and decode are ignored that cycle; the sources hold them, so they are re-seen on the first unstalled cycle.
- RUN, stall=0, priority order:
  - 1) ex_redirect=1: pc_fetch<=ex_target; flush_dec=1, flush_ex=1; pc_add_sel<=11 if ex_is_jalr else 01.
  - 2) dec_valid and opcode 1101111 (JAL): pc_fetch<=dec_pc+dec_imm (mod 2^32); flush_dec=1; pc_add_sel<=01.
  - 3) dec_valid and opcode 1100111 (JALR): pc_fetch holds; flush_dec=1; state<=JALR_WAIT.
  - 4) Otherwise: pc_fetch<=pc_fetch+4, wrapping 32'hFFFF_FFFC -> 0; pc_add_sel<=00.
- JALR_WAIT: fetch_valid=0; flush_dec=1 every cycle so decode holds a bubble; pc_fetch holds.
  - ex_redirect=1 and stall=0: pc_fetch<=ex_target, pc_add_sel<=11, state<=RUN, flush_ex=0. The JALR itself proceeds.
  - ex_redirect with ex_is_jalr=0 in this state is treated identically.
  - No timeout.
- Redirect penalty: JAL = 1 bubble; EX redirect = 2 bubbles; JALR = wait cycles + 1.
- Targets (JAL and ex_target) without the optional feature: bits [1:0] are forced to 0 before loading.

Optional Feature:
- MISALIGN_TRAP_EN defined: any JAL or EX target with bits[1:0]!=0 loads TRAP_VEC instead. Same flushes as the redirect; pc_add_sel<=10; trap=1 for exactly the following cycle; state<=RUN (including from JALR_WAIT).
- Undefined: target bits [1:0] are cleared silently; the trap port is tied 0; pc_add_sel never takes 10.

Test Plan:
- Reset, then 4 idle cycles -> BOOT cycle with fetch_valid=0 and pc=4000_0000; then pc 4000_0000, 4000_0004, 4000_0008, all fetch_valid=1, pc_add_sel=00.
- JAL in decode: dec_pc=4000_0010, dec_imm=0x100 -> next pc=4000_0110; flush_dec=1 for one cycle, flush_ex=0; pc_add_sel=01.
- JAL in decode and ex_redirect same cycle, ex_target=4000_0200 -> pc=4000_0200; flush_dec=flush_ex=1 (EX wins); pc_add_sel=01.
- JALR in decode, ex_redirect(ex_is_jalr=1, target 4000_0300) 3 cycles later -> fetch_valid=0 and flush_dec=1 throughout the wait; then pc=4000_0300, pc_add_sel=11, RUN.
- stall=1 for 2 cycles with ex_redirect held high -> pc and outputs frozen, flushes 0; redirect taken on the first stall=0 cycle. rst during JALR_WAIT -> BOOT, pc=4000_0000.
- ex_target=4000_0402: with MISALIGN_TRAP_EN -> pc=0000_1000, trap pulse 1 cycle, pc_add_sel=10; without -> pc=4000_0400, trap=0.
